// File: rtl/baud_gen.sv
// Fractional baud-rate generator: oversample, mid-bit and end-of-bit ticks plus a
// baud-rate square wave, with a shadowed runtime divisor and start-edge resync.
module baud_gen #(
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 8,
    parameter int unsigned DEFAULT_DIV  = 19,
    parameter int unsigned DEFAULT_FRAC = 136
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_sync,
    output logic              o_os_tick,
    output logic              o_mid_tick,
    output logic              o_baud_tick,
    output logic              o_clk
);

    localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2);
    localparam logic [DIV_W-1:0]  RST_DIV  = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0]  div_q, div_d, sdiv_q, sdiv_d, cnt_q, cnt_d;
    logic [FRAC_W-1:0] frac_q, frac_d, sfrac_q, sfrac_d, acc_q, acc_d;
    logic              pend_q, pend_d, extra_q, extra_d;
    logic [OS_W-1:0]   os_q, os_d;
    logic              os_tick_q, os_tick_d, mid_q, mid_d, baud_q, baud_d, clk_q, clk_d;

    logic [DIV_W-1:0]  eff_div;
    logic [FRAC_W-1:0] eff_frac;
    logic [DIV_W:0]    cnt_next, period_len;

    // A period lasts div cycles, plus one when the last fractional add carried.
    assign cnt_next   = {1'b0, cnt_q} + (DIV_W + 1)'(1);
    assign period_len = {1'b0, div_q} + {{DIV_W{1'b0}}, extra_q};

    always_comb begin
        div_d     = div_q;
        frac_d    = frac_q;
        sdiv_d    = sdiv_q;
        sfrac_d   = sfrac_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        extra_d   = extra_q;
        os_d      = os_q;
        clk_d     = clk_q;
        os_tick_d = 1'b0;
        mid_d     = 1'b0;
        baud_d    = 1'b0;
        eff_div   = pend_q ? sdiv_q  : div_q;
        eff_frac  = pend_q ? sfrac_q : frac_q;

        if (i_load) begin
            sdiv_d  = clamp_div(i_div);
            sfrac_d = i_frac;
            pend_d  = 1'b1;
        end

        if (i_sync) begin
            // A load in the sync cycle bypasses the shadow and takes effect at once.
            if (i_load) begin
                eff_div  = clamp_div(i_div);
                eff_frac = i_frac;
            end
            div_d   = eff_div;
            frac_d  = eff_frac;
            pend_d  = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
            extra_d = 1'b0;
            os_d    = '0;
            clk_d   = 1'b0;
        end else if (i_en) begin
            if (cnt_next == period_len) begin
                cnt_d              = '0;
                div_d              = eff_div;
                frac_d             = eff_frac;
                pend_d             = i_load;
                {extra_d, acc_d}   = {1'b0, acc_q} + {1'b0, eff_frac};
                os_tick_d          = 1'b1;
                if (os_q == OS_LAST) begin
                    os_d   = '0;
                    baud_d = 1'b1;
                    clk_d  = 1'b0;
                end else begin
                    os_d = os_q + OS_W'(1);
                    if (os_q + OS_W'(1) == OS_HALF) begin
                        mid_d = 1'b1;
                        clk_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_q     <= RST_DIV;
            frac_q    <= RST_FRAC;
            sdiv_q    <= RST_DIV;
            sfrac_q   <= RST_FRAC;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            extra_q   <= 1'b0;
            os_q      <= '0;
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            baud_q    <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            frac_q    <= frac_d;
            sdiv_q    <= sdiv_d;
            sfrac_q   <= sfrac_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            extra_q   <= extra_d;
            os_q      <= os_d;
            os_tick_q <= os_tick_d;
            mid_q     <= mid_d;
            baud_q    <= baud_d;
            clk_q     <= clk_d;
        end
    end

    assign o_os_tick   = os_tick_q;
    assign o_mid_tick  = mid_q;
    assign o_baud_tick = baud_q;
    assign o_clk       = clk_q;

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: tick times are predicted arithmetically from the divisor and
// compared with edge-stamped outputs recorded every cycle.
module tb_baud_gen;

    localparam int FSCALE = 256;

    logic        clk = 1'b0;
    logic        rstn = 1'b0, en = 1'b0, load = 1'b0, sync = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  frac = '0;
    logic        os_tick, mid_tick, baud_tick, bclk;

    baud_gen #(
        .OVERSAMPLE  (16),
        .DIV_W       (16),
        .FRAC_W      (8),
        .DEFAULT_DIV (19),
        .DEFAULT_FRAC(136)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_en       (en),
        .i_load     (load),
        .i_div      (div),
        .i_frac     (frac),
        .i_sync     (sync),
        .o_os_tick  (os_tick),
        .o_mid_tick (mid_tick),
        .o_baud_tick(baud_tick),
        .o_clk      (bclk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Each event is stamped with the number of the rising edge that produced it.
    int   os_q[$], mid_q[$], baud_q[$], rise_q[$], fall_q[$];
    logic clk_prev = 1'b0;
    always @(negedge clk) begin
        if (os_tick === 1'b1)   os_q.push_back(cyc);
        if (mid_tick === 1'b1)  mid_q.push_back(cyc);
        if (baud_tick === 1'b1) baud_q.push_back(cyc);
        if (bclk === 1'b1 && clk_prev === 1'b0) rise_q.push_back(cyc);
        if (bclk === 1'b0 && clk_prev === 1'b1) fall_q.push_back(cyc);
        clk_prev <= bclk;
    end

    int checks = 0, passed = 0;
    int g_base, g_d, g_f;

    // n-th tick after a restart at edge base: n*d cycles plus one per accumulator carry.
    function automatic int tick_at(input int base, input int d, input int f, input int n);
        return base + n * d + ((n - 1) * f) / FSCALE;
    endfunction

    function automatic int next_tick_after(input int c);
        int n = 1;
        while (tick_at(g_base, g_d, g_f, n) <= c) n++;
        return tick_at(g_base, g_d, g_f, n);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        os_q.delete(); mid_q.delete(); baud_q.delete(); rise_q.delete(); fall_q.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({os_tick, mid_tick, baud_tick, bclk} !== 4'b0)
            $display("FAIL reset_outputs: got %b want 0000", {os_tick, mid_tick, baud_tick, bclk}); else passed++;
        step(3);
        checks++; if ({os_tick, mid_tick, baud_tick, bclk} !== 4'b0)
            $display("FAIL reset_held_outputs: got %b want 0000", {os_tick, mid_tick, baud_tick, bclk}); else passed++;
        clear_q();
        rstn = 1'b1;
        en   = 1'b1;
        g_base = cyc; g_d = 19; g_f = 136;
    endtask

    task automatic test_default_rate();
        int guard, bad, r, sp;
        r = g_base; guard = 0;
        while (os_q.size() < 257 && guard < 6000) begin step(1); guard++; end
        checks++;
        if (os_q.size() < 257) begin
            $display("FAIL default_tick_count: got %0d want 257", os_q.size());
        end else begin
            passed++;
            checks++; if (os_q[0] !== r + 19)
                $display("FAIL default_first_tick: got %0d want %0d", os_q[0] - r, 19); else passed++;
            bad = 0;
            for (int n = 1; n <= 257; n++) if (os_q[n-1] != tick_at(r, 19, 136, n)) bad++;
            checks++; if (bad !== 0)
                $display("FAIL default_schedule: got %0d wrong ticks want 0", bad); else passed++;
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                sp = os_q[k+1] - os_q[k];
                if (sp != 19 && sp != 20) bad++;
            end
            checks++; if (bad !== 0)
                $display("FAIL default_spacing: got %0d bad spacings want 0", bad); else passed++;
            checks++; if (os_q[256] - os_q[0] !== 5000)
                $display("FAIL default_256_ticks: got %0d want 5000", os_q[256] - os_q[0]); else passed++;
            bad = 0;
            if (baud_q.size() < 16 || mid_q.size() < 16) bad = 99;
            else for (int k = 0; k < 16; k++) begin
                if (baud_q[k] != os_q[16*k+15]) bad++;
                if (mid_q[k] != os_q[16*k+7]) bad++;
            end
            checks++; if (bad !== 0)
                $display("FAIL default_bit_ticks: got %0d misplaced want 0", bad); else passed++;
        end
    endtask

    task automatic test_load();
        int nt, bad, fidx;
        step(int'($urandom_range(3, 15)));
        while (next_tick_after(cyc) == cyc + 1) step(1);
        nt = next_tick_after(cyc);
        clear_q();
        load = 1'b1; div = 16'd4; frac = 8'd0;
        step(1);
        load = 1'b0;
        step(250);
        checks++; if (os_q.size() < 10 || os_q[0] !== nt)
            $display("FAIL load_old_period: got %0d want %0d", (os_q.size() > 0) ? os_q[0] : -1, nt); else passed++;
        bad = 0;
        for (int k = 0; k + 1 < os_q.size(); k++) if (os_q[k+1] - os_q[k] != 4) bad++;
        checks++; if (bad !== 0)
            $display("FAIL load_spacing: got %0d bad spacings want 0", bad); else passed++;
        checks++; if (rise_q.size() < 2 || rise_q[1] - rise_q[0] !== 64)
            $display("FAIL load_clk_period: got %0d want 64", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1); else passed++;
        fidx = -1;
        for (int k = fall_q.size() - 1; k >= 0; k--) if (rise_q.size() > 0 && fall_q[k] > rise_q[0]) fidx = k;
        checks++; if (fidx < 0 || fall_q[fidx] - rise_q[0] !== 32)
            $display("FAIL load_clk_duty: got %0d want 32", (fidx >= 0) ? fall_q[fidx] - rise_q[0] : -1); else passed++;
        g_base = nt - 4; g_d = 4; g_f = 0;
    endtask

    task automatic test_sync(input bit aligned);
        int s, target;
        if (aligned) begin
            target = next_tick_after(cyc + int'($urandom_range(1, 40)));
            while (cyc + 1 < target) step(1);
        end else begin
            step(int'($urandom_range(1, 30)));
        end
        s = cyc + 1;
        clear_q();
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++; if ({os_tick, mid_tick, baud_tick, bclk} !== 4'b0)
            $display("FAIL sync_cycle_quiet: got %b want 0000", {os_tick, mid_tick, baud_tick, bclk}); else passed++;
        step(16 * g_d + 8);
        checks++; if (os_q.size() == 0 || os_q[0] !== s + g_d)
            $display("FAIL sync_first_os: got %0d want %0d", (os_q.size() > 0) ? os_q[0] - s : -1, g_d); else passed++;
        checks++; if (mid_q.size() == 0 || mid_q[0] !== s + 8 * g_d)
            $display("FAIL sync_mid: got %0d want %0d", (mid_q.size() > 0) ? mid_q[0] - s : -1, 8 * g_d); else passed++;
        checks++; if (baud_q.size() == 0 || baud_q[0] !== s + 16 * g_d)
            $display("FAIL sync_baud: got %0d want %0d", (baud_q.size() > 0) ? baud_q[0] - s : -1, 16 * g_d); else passed++;
        checks++; if (rise_q.size() == 0 || rise_q[0] !== s + 8 * g_d)
            $display("FAIL sync_clk_low: got %0d want %0d", (rise_q.size() > 0) ? rise_q[0] - s : -1, 8 * g_d); else passed++;
        g_base = s;
    endtask

    task automatic test_load_sync();
        int s, d_in, d, f, bad;
        d_in = int'($urandom_range(0, 12));
        d    = (d_in < 2) ? 2 : d_in;
        f    = int'($urandom_range(0, 255));
        step(int'($urandom_range(1, 20)));
        s = cyc + 1;
        clear_q();
        load = 1'b1; sync = 1'b1; div = 16'(d_in); frac = 8'(f);
        step(1);
        load = 1'b0; sync = 1'b0;
        step(17 * d + 24);
        bad = 0;
        if (os_q.size() < 16) bad = 99;
        else for (int n = 1; n <= 16; n++) if (os_q[n-1] != tick_at(s, d, f, n)) bad++;
        checks++; if (bad !== 0)
            $display("FAIL load_sync_schedule: got %0d wrong (div %0d frac %0d) want 0", bad, d_in, f); else passed++;
        checks++; if (mid_q.size() == 0 || mid_q[0] !== tick_at(s, d, f, 8))
            $display("FAIL load_sync_mid: got %0d want %0d", (mid_q.size() > 0) ? mid_q[0] : -1, tick_at(s, d, f, 8)); else passed++;
        checks++; if (baud_q.size() == 0 || baud_q[0] !== tick_at(s, d, f, 16))
            $display("FAIL load_sync_baud: got %0d want %0d", (baud_q.size() > 0) ? baud_q[0] : -1, tick_at(s, d, f, 16)); else passed++;
        g_base = s; g_d = d; g_f = f;
    endtask

    task automatic test_enable();
        int c, n0, bad;
        logic clk0;
        step(int'($urandom_range(3, 25)));
        c = cyc;
        clk0 = bclk;
        clear_q();
        en = 1'b0;
        bad = 0;
        repeat (37) begin
            step(1);
            if ({os_tick, mid_tick, baud_tick} !== 3'b0 || bclk !== clk0) bad++;
        end
        en = 1'b1;
        checks++; if (bad !== 0)
            $display("FAIL enable_hold_quiet: got %0d active cycles want 0", bad); else passed++;
        step(10 * g_d + 30);
        n0 = 1;
        while (tick_at(g_base, g_d, g_f, n0) <= c) n0++;
        bad = 0;
        if (os_q.size() < 8) bad = 99;
        else for (int k = 0; k < 8; k++) if (os_q[k] != tick_at(g_base, g_d, g_f, n0 + k) + 37) bad++;
        checks++; if (bad !== 0)
            $display("FAIL enable_resume: got %0d late/early ticks want 0", bad); else passed++;
        g_base = g_base + 37;
    endtask

    task automatic test_min_div();
        int nt, bad, d_in;
        d_in = int'($urandom_range(0, 1));
        step(int'($urandom_range(2, 12)));
        while (next_tick_after(cyc) == cyc + 1) step(1);
        nt = next_tick_after(cyc);
        clear_q();
        load = 1'b1; div = 16'(d_in); frac = 8'd0;
        step(1);
        load = 1'b0;
        step(60);
        checks++; if (os_q.size() < 10 || os_q[0] !== nt)
            $display("FAIL min_div_boundary: got %0d want %0d", (os_q.size() > 0) ? os_q[0] : -1, nt); else passed++;
        bad = 0;
        for (int k = 0; k + 1 < os_q.size(); k++) if (os_q[k+1] - os_q[k] != 2) bad++;
        checks++; if (bad !== 0)
            $display("FAIL min_div_spacing: got %0d bad spacings (div %0d) want 0", bad, d_in); else passed++;
        g_base = nt - 2; g_d = 2; g_f = 0;
    endtask

    task automatic test_async_reset();
        int guard, r;
        guard = 0;
        while (bclk !== 1'b1 && guard < 200) begin step(1); guard++; end
        checks++; if (bclk !== 1'b1)
            $display("FAIL async_reset_setup: got o_clk %b want 1", bclk); else passed++;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checks++; if ({os_tick, mid_tick, baud_tick, bclk} !== 4'b0)
            $display("FAIL async_reset_immediate: got %b want 0000", {os_tick, mid_tick, baud_tick, bclk}); else passed++;
        step(2);
        r = cyc;
        clear_q();
        rstn = 1'b1;
        step(50);
        checks++; if (os_q.size() < 2 || os_q[0] !== r + 19)
            $display("FAIL async_reset_first_tick: got %0d want 19", (os_q.size() > 0) ? os_q[0] - r : -1); else passed++;
        checks++; if (os_q.size() < 2 || os_q[1] !== r + 38)
            $display("FAIL async_reset_second_tick: got %0d want 38", (os_q.size() > 1) ? os_q[1] - r : -1); else passed++;
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_load();
        test_sync(1'b1);
        test_sync(1'b0);
        repeat (3) test_load_sync();
        test_enable();
        test_min_div();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
